// File: rtl/pc_fetch_ctrl_if.sv
// Bundles the PC register, instruction memory, decode and redirect signals
// of the fetch sequencer. master = sequencer side, slave = surrounding pipeline.
interface pc_fetch_ctrl_if;
    logic [31:0] pc_cur;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fault;

    modport master (
        input  pc_cur, imem_ack, imem_rdata, instr_ready, branch_taken, branch_target,
        output pc_ena, pc_next, imem_req, imem_addr, instr, instr_valid, fault
    );

    modport slave (
        output pc_cur, imem_ack, imem_rdata, instr_ready, branch_taken, branch_target,
        input  pc_ena, pc_next, imem_req, imem_addr, instr, instr_valid, fault
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Next-PC and fetch sequencer: req/ack fetch from imem, holds the word for decode,
// and steers the PC register to pc+4 or to the most recent branch redirect.
module pc_fetch_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        redir_pend;
    logic [31:0] redir_tgt;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        fault_q;
    logic        req_c;
    logic        ena_c;
    logic [31:0] next_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        ena_c     = 1'b0;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                req_c = 1'b1;
                // an ack arriving on the last allowed cycle still wins
                if (bus.imem_ack)               state_nxt = VALID;
                else if (wait_cnt == WAIT_LAST) state_nxt = FAULT;
            end
            VALID: begin
                if (bus.instr_ready) begin
                    ena_c     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt      <= 8'd0;
            redir_pend    <= 1'b0;
            redir_tgt     <= 32'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            if (state == FETCH) begin
                if (bus.imem_ack) begin
                    instr_q       <= bus.imem_rdata;
                    instr_valid_q <= 1'b1;
                    wait_cnt      <= 8'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
            if (ena_c) instr_valid_q <= 1'b0;
            // a branch in the retiring cycle is consumed directly via pc_next
            if (bus.branch_taken && !ena_c) begin
                redir_pend <= 1'b1;
                redir_tgt  <= bus.branch_target;
            end else if (ena_c) begin
                redir_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        if (bus.branch_taken) next_c = bus.branch_target & 32'hFFFF_FFFC;
        else if (redir_pend)  next_c = redir_tgt & 32'hFFFF_FFFC;
        else                  next_c = bus.pc_cur + 32'd4;
    end

    assign bus.imem_req    = req_c;
    assign bus.imem_addr   = bus.pc_cur;
    assign bus.pc_ena      = ena_c;
    assign bus.pc_next     = next_c;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus a randomized run checked against
// a model that tracks the expected PC stream and the last redirect per retirement.
module tb_pc_fetch_ctrl;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // one clock; the bench plays the PC register, loading pc_next when pc_ena
    task automatic cyc();
        logic        ena;
        logic [31:0] nxt;
        #1;
        ena = bus.pc_ena;
        nxt = bus.pc_next;
        @(posedge clk);
        #1;
        if (ena) bus.pc_cur = nxt;
    endtask

    task automatic set_idle();
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'd0;
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
    endtask

    // leaves the DUT in its first FETCH cycle with pc_cur = start
    task automatic do_reset(input logic [31:0] start);
        rst = 1'b1;
        set_idle();
        bus.pc_cur = start;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        bus.pc_cur = 32'h0000_0080;
        @(posedge clk);
        #1;
        n_chk++;
        if ({bus.imem_req, bus.pc_ena, bus.instr_valid, bus.fault, bus.instr} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {bus.imem_req, bus.pc_ena, bus.instr_valid, bus.fault, bus.instr});
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_cycle: req=%b want 0", bus.imem_req);
        end
        cyc();
        n_chk++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_0080}) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got %h want %h", {bus.imem_req, bus.imem_addr},
                     {1'b1, 32'h0000_0080});
        end
        cyc();
        rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.imem_req, bus.fault} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: req,fault=%b want 00", {bus.imem_req, bus.fault});
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        cyc();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bus.imem_req, bus.instr_valid, bus.instr} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_late_ack: got %h want 0", {bus.imem_req, bus.instr_valid, bus.instr});
        end
        cyc();
        bus.imem_ack = 1'b0;
        #1;
        n_chk++;
        if ({bus.imem_req, bus.instr_valid, bus.instr} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got %h want %h", {bus.imem_req, bus.instr_valid, bus.instr},
                     {1'b1, 1'b0, 32'h0});
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        logic [31:0] word;
        do_reset(32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'(4 * k);
            word   = 32'h1234_5678 + 32'(k);
            for (int c = 0; c < 2; c++) begin
                #1;
                n_chk++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_pc}) begin
                    n_fail++;
                    $display("FAIL seq_fetch: got %h want %h", {bus.imem_req, bus.imem_addr}, {1'b1, exp_pc});
                end
                cyc();
            end
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = word;
            cyc();
            bus.imem_ack    = 1'b0;
            bus.instr_ready = 1'b1;
            #1;
            n_chk++;
            if ({bus.instr_valid, bus.instr, bus.pc_ena, bus.pc_next} !== {1'b1, word, 1'b1, exp_pc + 32'd4}) begin
                n_fail++;
                $display("FAIL seq_handshake: got %h want %h", {bus.instr_valid, bus.instr, bus.pc_ena, bus.pc_next},
                         {1'b1, word, 1'b1, exp_pc + 32'd4});
            end
            cyc();
            bus.instr_ready = 1'b0;
        end
        #1;
        n_chk++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd16}) begin
            n_fail++;
            $display("FAIL seq_after: got %h want %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'd16});
        end
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFC);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_00A5;
        cyc();
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        n_chk++;
        if ({bus.pc_ena, bus.pc_next} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_next: got %h want %h", {bus.pc_ena, bus.pc_next}, {1'b1, 32'h0});
        end
        cyc();
        bus.instr_ready = 1'b0;
        #1;
        n_chk++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_fetch: got %h want %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});
        end
    endtask

    task automatic test_branch();
        do_reset(32'h40);
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0103;
        cyc();
        bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h11;
        cyc();
        bus.imem_ack = 1'b0;
        #1;
        n_chk++;
        if ({bus.pc_ena, bus.pc_next} !== {1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL br_pending: got %h want %h", {bus.pc_ena, bus.pc_next}, {1'b0, 32'h100});
        end
        bus.instr_ready = 1'b1;
        #1;
        n_chk++;
        if ({bus.pc_ena, bus.pc_next, bus.instr} !== {1'b1, 32'h100, 32'h11}) begin
            n_fail++;
            $display("FAIL br_handshake: got %h want %h", {bus.pc_ena, bus.pc_next, bus.instr},
                     {1'b1, 32'h100, 32'h11});
        end
        cyc();
        bus.instr_ready = 1'b0;
        #1;
        n_chk++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL br_fetch: got %h want %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h100});
        end
        // a later branch replaces the pending one
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0103;
        cyc();
        bus.branch_taken = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h22;
        cyc();
        bus.imem_ack = 1'b0;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0200;
        cyc();
        bus.branch_taken = 1'b0;
        bus.instr_ready  = 1'b1;
        #1;
        n_chk++;
        if ({bus.pc_ena, bus.pc_next} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL br_last_wins: got %h want %h", {bus.pc_ena, bus.pc_next}, {1'b1, 32'h200});
        end
        cyc();
        bus.instr_ready = 1'b0;
        // fresh branch in the handshake cycle beats the pending one and clears it
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0300;
        cyc();
        bus.branch_taken = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h33;
        cyc();
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0404;
        #1;
        n_chk++;
        if ({bus.pc_ena, bus.pc_next} !== {1'b1, 32'h404}) begin
            n_fail++;
            $display("FAIL br_fresh_wins: got %h want %h", {bus.pc_ena, bus.pc_next}, {1'b1, 32'h404});
        end
        cyc();
        bus.instr_ready = 1'b0; bus.branch_taken = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h44;
        cyc();
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        #1;
        n_chk++;
        if ({bus.pc_ena, bus.pc_next} !== {1'b1, 32'h408}) begin
            n_fail++;
            $display("FAIL br_cleared: got %h want %h", {bus.pc_ena, bus.pc_next}, {1'b1, 32'h408});
        end
        cyc();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset(32'h1000);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack   = (i == 2);
            bus.imem_rdata = 32'hBAD0_0000 + 32'(i);
            #1;
            n_chk++;
            if ({bus.instr_valid, bus.instr, bus.pc_ena, bus.imem_req} !== {1'b1, 32'hCAFE_F00D, 2'b00}) begin
                n_fail++;
                $display("FAIL bp_hold: got %h want %h", {bus.instr_valid, bus.instr, bus.pc_ena, bus.imem_req},
                         {1'b1, 32'hCAFE_F00D, 2'b00});
            end
            cyc();
        end
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        #1;
        n_chk++;
        if ({bus.pc_ena, bus.pc_next, bus.instr} !== {1'b1, 32'h1004, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL bp_release: got %h want %h", {bus.pc_ena, bus.pc_next, bus.instr},
                     {1'b1, 32'h1004, 32'hCAFE_F00D});
        end
        cyc();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset(32'h2000);
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            #1;
            n_chk++;
            if ({bus.imem_req, bus.fault} !== 2'b10) begin
                n_fail++;
                $display("FAIL to_wait: cycle %0d req,fault=%b want 10", c, {bus.imem_req, bus.fault});
            end
            cyc();
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h77;
        cyc();
        bus.imem_ack = 1'b0;
        #1;
        n_chk++;
        if ({bus.instr_valid, bus.instr, bus.fault} !== {1'b1, 32'h77, 1'b0}) begin
            n_fail++;
            $display("FAIL to_ack_last: got %h want %h", {bus.instr_valid, bus.instr, bus.fault},
                     {1'b1, 32'h77, 1'b0});
        end
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            #1;
            n_chk++;
            if ({bus.imem_req, bus.fault} !== 2'b10) begin
                n_fail++;
                $display("FAIL to_wait2: cycle %0d req,fault=%b want 10", c, {bus.imem_req, bus.fault});
            end
            cyc();
        end
        bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if ({bus.fault, bus.imem_req, bus.pc_ena, bus.instr_valid} !== 4'b1000) begin
                n_fail++;
                $display("FAIL to_fault: cycle %0d got %b want 1000", c,
                         {bus.fault, bus.imem_req, bus.pc_ena, bus.instr_valid});
            end
            cyc();
        end
        set_idle();
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL to_rst_clear: fault=%b want 0", bus.fault);
        end
    endtask

    // model: each retirement loads the last branch seen since the previous one, else pc+4
    task automatic test_random();
        logic [31:0] exp_pc, word, want, br_tgt, start;
        logic        br_seen;
        int          ack_dly, rdy_dly;
        start = $urandom() & 32'hFFFF_FFFC;
        do_reset(start);
        exp_pc  = start;
        br_seen = 1'b0;
        br_tgt  = 32'h0;
        for (int n = 0; n < 40; n++) begin
            ack_dly = $urandom_range(0, 4);
            rdy_dly = $urandom_range(0, 3);
            word    = $urandom();
            for (int c = 0; c <= ack_dly; c++) begin
                bus.imem_ack   = (c == ack_dly);
                bus.imem_rdata = (c == ack_dly) ? word : $urandom();
                bus.branch_taken  = ($urandom_range(0, 5) == 0);
                bus.branch_target = $urandom();
                if (bus.branch_taken) begin br_seen = 1'b1; br_tgt = bus.branch_target; end
                #1;
                n_chk++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_pc}) begin
                    n_fail++;
                    $display("FAIL rnd_fetch: instr %0d got %h want %h", n, {bus.imem_req, bus.imem_addr},
                             {1'b1, exp_pc});
                end
                cyc();
            end
            for (int c = 0; c <= rdy_dly; c++) begin
                bus.instr_ready   = (c == rdy_dly);
                bus.imem_ack      = ($urandom_range(0, 3) == 0);
                bus.imem_rdata    = $urandom();
                bus.branch_taken  = ($urandom_range(0, 5) == 0);
                bus.branch_target = $urandom();
                if (bus.branch_taken) begin br_seen = 1'b1; br_tgt = bus.branch_target; end
                #1;
                if (c == rdy_dly) begin
                    want = br_seen ? (br_tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
                    n_chk++;
                    if ({bus.instr_valid, bus.instr, bus.pc_ena, bus.pc_next} !== {1'b1, word, 1'b1, want}) begin
                        n_fail++;
                        $display("FAIL rnd_retire: instr %0d got %h want %h", n,
                                 {bus.instr_valid, bus.instr, bus.pc_ena, bus.pc_next}, {1'b1, word, 1'b1, want});
                    end
                    exp_pc  = want;
                    br_seen = 1'b0;
                end else begin
                    n_chk++;
                    if ({bus.instr_valid, bus.instr, bus.pc_ena} !== {1'b1, word, 1'b0}) begin
                        n_fail++;
                        $display("FAIL rnd_hold: instr %0d got %h want %h", n,
                                 {bus.instr_valid, bus.instr, bus.pc_ena}, {1'b1, word, 1'b0});
                    end
                end
                cyc();
            end
            set_idle();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        bus.pc_cur = 32'h0;
        test_reset();
        test_sequential();
        test_wrap();
        test_branch();
        test_backpressure();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
